program_encoder: RTL and testbench

//  Sequential instruction encoder/loader: accepts assembler-level instruction fields over a

---
 rtl/program_encoder.sv | 186 ++++++++++++++++++
 tb/tb_program_encoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_encoder.sv
// Instruction loader: packs assembler-level fields into KGP-RISC words and writes them
// consecutively from BASE_ADDR. Define ENC_READBACK_EN to add a read-after-write verify pass.
module program_encoder #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words,
    output logic              done,
    output logic              err_illegal
`ifdef ENC_READBACK_EN
    ,
    input  logic [31:0]       imem_rdata,
    output logic              rb_mismatch
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_VERIFY, S_CHECK, S_DONE
    } state_e;

    typedef enum logic [2:0] {K_R, K_BR, K_I, K_J, K_RET, K_BAD} kind_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);

    state_e          state_q, state_d;
    logic [ADDR_W:0] words_q;
    logic [31:0]     data_q;
    logic            last_q;
    logic            err_q;
    logic            accept;
    logic            finish;
    enc_t            enc;

    function automatic enc_t encode(input logic [4:0] mnem, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [25:0] imm);
        kind_e      kind;
        logic [5:0] code;
        logic [4:0] shamt;
        enc_t       r;
        kind  = K_BAD;
        code  = 6'b000000;
        r     = '0;
        case (mnem)
            5'd0:  begin kind = K_R;   code = 6'b100000; end
            5'd1:  begin kind = K_R;   code = 6'b011000; end
            5'd2:  begin kind = K_R;   code = 6'b011001; end
            5'd3:  begin kind = K_R;   code = 6'b100100; end
            5'd4:  begin kind = K_R;   code = 6'b100110; end
            5'd5:  begin kind = K_R;   code = 6'b100111; end
            5'd6:  begin kind = K_R;   code = 6'b000000; end
            5'd7:  begin kind = K_R;   code = 6'b000010; end
            5'd8:  begin kind = K_R;   code = 6'b000011; end
            5'd9:  begin kind = K_R;   code = 6'b000100; end
            5'd10: begin kind = K_R;   code = 6'b000110; end
            5'd11: begin kind = K_R;   code = 6'b000111; end
            5'd12: begin kind = K_BR;  code = 6'b001000; end
            5'd13: begin kind = K_I;   code = 6'b001000; end
            5'd14: begin kind = K_I;   code = 6'b001100; end
            5'd15: begin kind = K_I;   code = 6'b100011; end
            5'd16: begin kind = K_I;   code = 6'b101011; end
            5'd17: begin kind = K_J;   code = 6'b010000; end
            5'd18: begin kind = K_J;   code = 6'b010010; end
            5'd19: begin kind = K_J;   code = 6'b010011; end
            5'd20: begin kind = K_J;   code = 6'b010100; end
            5'd21: begin kind = K_J;   code = 6'b010101; end
            5'd22: begin kind = K_J;   code = 6'b010110; end
            5'd23: begin kind = K_J;   code = 6'b010111; end
            5'd24: begin kind = K_J;   code = 6'b011000; end
            5'd25: begin kind = K_J;   code = 6'b011001; end
            5'd26: begin kind = K_J;   code = 6'b011010; end
            5'd27: begin kind = K_RET; code = 6'b011011; end
            default: kind = K_BAD;
        endcase
        // Only the immediate shifts carry a shift amount; variable shifts take it from rt.
        shamt = (mnem inside {5'd6, 5'd7, 5'd8}) ? imm[4:0] : 5'd0;
        case (kind)
            K_R:     r = '{legal: 1'b1, word: {6'b000000, rs, rt, 5'd0, shamt, code}};
            K_BR:    r = '{legal: 1'b1, word: {6'b000000, rs, 15'd0, code}};
            K_I:     r = '{legal: 1'b1, word: {code, rs, rt, imm[15:0]}};
            K_J:     r = '{legal: 1'b1, word: {code, imm}};
            K_RET:   r = '{legal: 1'b1, word: {code, 26'd0}};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign enc    = encode(in_mnem, in_rs, in_rt, in_imm);
    assign accept = (state_q == S_LOAD) && in_valid;
    assign finish = last_q || ((words_q + ONE_W) == DEPTH_W);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (accept && enc.legal) state_d = S_WRITE;
`ifdef ENC_READBACK_EN
            S_WRITE:  state_d = S_VERIFY;
            S_VERIFY: state_d = S_CHECK;
            S_CHECK:  state_d = finish ? S_DONE : S_LOAD;
`else
            S_WRITE: state_d = finish ? S_DONE : S_LOAD;
`endif
            S_DONE:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // A reset arriving during WRITE must kill the strobe in that same cycle.
    always_comb begin
        in_ready  = (state_q == S_LOAD);
        imem_wren = (state_q == S_WRITE) && !rst;
        done      = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !enc.legal;
            if (accept && enc.legal) begin
                data_q <= enc.word;
                last_q <= in_last;
            end
`ifdef ENC_READBACK_EN
            if (state_q == S_CHECK) words_q <= words_q + ONE_W;
`else
            if (state_q == S_WRITE) words_q <= words_q + ONE_W;
`endif
            if (start && (state_q == S_IDLE || state_q == S_DONE)) words_q <= '0;
        end
    end

`ifdef ENC_READBACK_EN
    logic rb_q;

    // Address stays put through VERIFY so the 1-cycle read returns the word just written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_q <= 1'b0;
        end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            rb_q <= 1'b0;
        end else if (state_q == S_CHECK && imem_rdata != data_q) begin
            rb_q <= 1'b1;
        end
    end

    assign rb_mismatch = rb_q;
`endif

    assign imem_addr   = BASE_W + words_q[ADDR_W-1:0];
    assign imem_wdata  = data_q;
    assign words       = words_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_program_encoder.sv
// Scoreboard bench for program_encoder (DEPTH=4): expected writes are queued on accept and
// compared as the DUT strobes imem_wren. Define ENC_READBACK_EN to exercise the verify path.
module tb_program_encoder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_mnem = '0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [25:0]       in_imm = '0;
    logic              in_last = 1'b0;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words;
    logic              done;
    logic              err_illegal;
`ifdef ENC_READBACK_EN
    logic [31:0]       imem_rdata = '0;
    logic              rb_mismatch;
    logic              corrupt = 1'b0;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
`endif

    program_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mnem     (in_mnem),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_imm      (in_imm),
        .in_last     (in_last),
        .imem_wren   (imem_wren),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .words       (words),
        .done        (done),
        .err_illegal (err_illegal)
`ifdef ENC_READBACK_EN
        ,
        .imem_rdata  (imem_rdata),
        .rb_mismatch (rb_mismatch)
`endif
    );

    always #5 clk = ~clk;

`ifdef ENC_READBACK_EN
    always @(posedge clk) begin
        if (imem_wren) mem[imem_addr] <= imem_wdata;
        imem_rdata <= mem[imem_addr] ^ {31'd0, corrupt};
    end
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   exp_words = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Table-driven reference encoder: bit 32 = legal, [31:0] = word.
    function automatic logic [32:0] model(input logic [4:0] m, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [25:0] imm);
        logic [5:0] rf [13];
        logic [5:0] io [4];
        logic [5:0] jo [11];
        logic [4:0] sh;
        int         idx;
        rf = '{6'b100000, 6'b011000, 6'b011001, 6'b100100, 6'b100110, 6'b100111, 6'b000000,
               6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111, 6'b001000};
        io = '{6'b001000, 6'b001100, 6'b100011, 6'b101011};
        jo = '{6'b010000, 6'b010010, 6'b010011, 6'b010100, 6'b010101, 6'b010110,
               6'b010111, 6'b011000, 6'b011001, 6'b011010, 6'b011011};
        idx = int'(m);
        if (idx == 12) return {1'b1, 6'd0, rs, 15'd0, 6'b001000};
        if (idx < 12) begin
            sh = (idx >= 6 && idx <= 8) ? imm[4:0] : 5'd0;
            return {1'b1, 6'd0, rs, rt, 5'd0, sh, rf[idx]};
        end
        if (idx <= 16) return {1'b1, io[idx-13], rs, rt, imm[15:0]};
        if (idx == 27) return {1'b1, 6'b011011, 26'd0};
        if (idx <= 26) return {1'b1, jo[idx-17], imm};
        return 33'd0;
    endfunction

    always @(negedge clk) begin
        if (imem_wren) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {22'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", {22'd0, imem_addr}, e.addr);
                check("wr_data", imem_wdata, e.data);
                check("wr_words", {21'd0, words}, e.addr);
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_words = 0;
    endtask

    task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [25:0] imm, input logic last);
        int          n;
        logic [32:0] e;
        @(negedge clk);
        in_mnem = m; in_rs = rs; in_rt = rt; in_imm = imm; in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        e = model(m, rs, rt, imm);
        if (e[32]) begin
            exp_q.push_back('{addr: exp_words, data: e[31:0]});
            exp_words++;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_wren"},  {31'd0, imem_wren}, 32'd0);
        check({tag, "_addr"},  {22'd0, imem_addr}, 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_words"}, {21'd0, words}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_err"},   {31'd0, err_illegal}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rm;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Single ADDI, last.
        do_start();
        send(5'd13, 5'd1, 5'd3, 26'd5, 1'b1);
        wait_done();
        check("a_done", {31'd0, done}, 32'd1);
        check("a_words", {21'd0, words}, 32'd1);
        check("a_ready", {31'd0, in_ready}, 32'd0);

        // ADD then SHRA; a start pulse mid-load must be ignored.
        do_start();
        check("b_words0", {21'd0, words}, 32'd0);
        check("b_done0", {31'd0, done}, 32'd0);
        send(5'd0, 5'd1, 5'd2, 26'd0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(5'd8, 5'd4, 5'd0, 26'd3, 1'b1);
        wait_done();
        check("b_words", {21'd0, words}, 32'd2);

        // CALL then RET.
        do_start();
        send(5'd26, 5'd0, 5'd0, 26'h40, 1'b0);
        send(5'd27, 5'd0, 5'd0, 26'd0, 1'b1);
        wait_done();
        check("c_done", {31'd0, done}, 32'd1);
        check("c_ready", {31'd0, in_ready}, 32'd0);

        // Illegal mnemonic with in_last: dropped, pulse, load continues at same address.
        do_start();
        send(5'd29, 5'd1, 5'd1, 26'd1, 1'b1);
        @(negedge clk);
        check("d_err", {31'd0, err_illegal}, 32'd1);
        check("d_words", {21'd0, words}, 32'd0);
        check("d_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("d_err_pulse", {31'd0, err_illegal}, 32'd0);
        send(5'd13, 5'd2, 5'd5, 26'h000BEEF, 1'b1);
        wait_done();
        check("d_words_end", {21'd0, words}, 32'd1);

        // Random legal mix, three words.
        do_start();
        for (int i = 0; i < 3; i++) begin
            rm = 5'($urandom_range(0, 27));
            send(rm, 5'($urandom), 5'($urandom), 26'($urandom), i == 2);
        end
        wait_done();
        check("r_words", {21'd0, words}, 32'd3);

        // DEPTH boundary: four words without in_last, then a stalled fifth.
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(5'(9 + i), 5'(i), 5'(i + 1), 26'd0, 1'b0);
        end
        wait_done();
        check("e_done", {31'd0, done}, 32'd1);
        check("e_words", {21'd0, words}, 32'd4);
        in_mnem = 5'd0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("e_stall_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        // Reset asserted in the WRITE cycle suppresses the write.
        do_start();
        in_mnem = 5'd13; in_rs = 5'd7; in_rt = 5'd7; in_imm = 26'h1234; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("f");
        @(negedge clk);
        rst = 1'b0;

`ifdef ENC_READBACK_EN
        corrupt = 1'b1;
        do_start();
        send(5'd14, 5'd3, 5'd4, 26'h00F0, 1'b1);
        wait_done();
        check("rb_set", {31'd0, rb_mismatch}, 32'd1);
        corrupt = 1'b0;
        repeat (2) @(negedge clk);
        check("rb_sticky", {31'd0, rb_mismatch}, 32'd1);
        do_start();
        check("rb_clear", {31'd0, rb_mismatch}, 32'd0);
        send(5'd15, 5'd1, 5'd2, 26'h0004, 1'b1);
        wait_done();
        check("rb_clean", {31'd0, rb_mismatch}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
